// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush-to-bubble (ctrl zeroed, keep preserved) and a saturating flush counter.
module pipe_stage_skid #(
  parameter int KEEP_W = 72,
  parameter int CTRL_W = 24,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [KEEP_W-1:0] keep_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              bubble_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              r_m_vld;
  logic              r_m_bub;
  logic [KEEP_W-1:0] r_m_keep;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_s_vld;
  logic [KEEP_W-1:0] w_s_keep;
  logic [CTRL_W-1:0] w_s_ctrl;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_m_load;

  assign w_in_fire  = up_valid_i & up_ready_o;
  assign w_out_fire = r_m_vld & dn_ready_i;
  assign w_m_load   = !r_m_vld | w_out_fire;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_s_vld;
      logic              r_up_rdy;
      logic [KEEP_W-1:0] r_s_keep;
      logic [CTRL_W-1:0] r_s_ctrl;

      // r_up_rdy always mirrors !r_s_vld so upstream ready comes straight from a flop
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_s_vld  <= 1'b0;
          r_up_rdy <= 1'b1;
          r_s_keep <= '0;
          r_s_ctrl <= '0;
        end else if (flush_i) begin
          r_s_vld  <= 1'b0;
          r_up_rdy <= 1'b1;
        end else if (r_m_vld && !w_out_fire && w_in_fire) begin
          r_s_vld  <= 1'b1;
          r_up_rdy <= 1'b0;
          r_s_keep <= keep_i;
          r_s_ctrl <= ctrl_i;
        end else if (w_m_load) begin
          r_s_vld  <= 1'b0;
          r_up_rdy <= 1'b1;
        end
      end

      assign w_s_vld    = r_s_vld;
      assign w_s_keep   = r_s_keep;
      assign w_s_ctrl   = r_s_ctrl;
      assign up_ready_o = r_up_rdy;
    end else begin : g_noskid
      assign w_s_vld    = 1'b0;
      assign w_s_keep   = '0;
      assign w_s_ctrl   = '0;
      assign up_ready_o = !r_m_vld | dn_ready_i;
    end
  endgenerate

  // Flush wins; data regs are only written on an actual load so an idle stage stays quiet
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m_vld  <= 1'b0;
      r_m_bub  <= 1'b0;
      r_m_keep <= '0;
      r_m_ctrl <= '0;
    end else if (flush_i) begin
      if (w_in_fire) begin
        r_m_vld  <= 1'b1;
        r_m_bub  <= 1'b1;
        r_m_keep <= keep_i;
        r_m_ctrl <= '0;
      end else begin
        r_m_vld  <= 1'b0;
        r_m_bub  <= 1'b0;
        r_m_ctrl <= '0;
      end
    end else if (w_m_load) begin
      r_m_bub <= 1'b0;
      if (w_s_vld) begin
        r_m_vld  <= 1'b1;
        r_m_keep <= w_s_keep;
        r_m_ctrl <= w_s_ctrl;
      end else if (w_in_fire) begin
        r_m_vld  <= 1'b1;
        r_m_keep <= keep_i;
        r_m_ctrl <= ctrl_i;
      end else begin
        r_m_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      r_cnt <= '0;
    else if (flush_i && r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign dn_valid_o  = r_m_vld;
  assign bubble_o    = r_m_bub;
  assign keep_o      = r_m_keep;
  assign ctrl_o      = r_m_ctrl;
  assign flush_cnt_o = r_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + scoreboard bench for pipe_stage_skid; runs a SKID=1 and a SKID=0 instance
// side by side on shared stimulus, both with a 2-bit flush counter.
module tb_pipe_stage_skid;
  localparam int KW = 72;
  localparam int CW = 24;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, up_valid = 1'b0, dn_ready = 1'b0;
  logic [KW-1:0] keep_in = '0;
  logic [CW-1:0] ctrl_in = '0;

  logic rdy1, vld1, bub1, rdy0, vld0, bub0;
  logic [KW-1:0] k1, k0;
  logic [CW-1:0] c1, c0;
  logic [1:0] cnt1, cnt0;

  int n_cmp = 0, n_bad = 0;
  bit sb_en = 1'b0;
  typedef logic [KW+CW-1:0] ent_t;
  ent_t q1[$], q0[$];
  ent_t e1, e0;

  pipe_stage_skid #(.KEEP_W(KW), .CTRL_W(CW), .SKID(1), .CNT_W(2)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(rdy1),
    .keep_i(keep_in), .ctrl_i(ctrl_in), .dn_valid_o(vld1), .dn_ready_i(dn_ready),
    .keep_o(k1), .ctrl_o(c1), .bubble_o(bub1), .flush_cnt_o(cnt1));

  pipe_stage_skid #(.KEEP_W(KW), .CTRL_W(CW), .SKID(0), .CNT_W(2)) u_s0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(rdy0),
    .keep_i(keep_in), .ctrl_i(ctrl_in), .dn_valid_o(vld0), .dn_ready_i(dn_ready),
    .keep_o(k0), .ctrl_o(c0), .bubble_o(bub0), .flush_cnt_o(cnt0));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Scoreboard: fires are sampled mid-cycle while inputs and outputs are stable
  always @(negedge clk) begin
    if (sb_en) begin
      if (vld1 && dn_ready) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_bad++; $display("FAIL sb_s1_dup: got keep=%h, required no output", k1);
        end else begin
          e1 = q1.pop_front();
          if ({bub1, k1, c1} !== {1'b0, e1}) begin
            n_bad++; $display("FAIL sb_s1_order: got b=%b %h required b=0 %h", bub1, {k1, c1}, e1);
          end
        end
      end
      if (vld0 && dn_ready) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_bad++; $display("FAIL sb_s0_dup: got keep=%h, required no output", k0);
        end else begin
          e0 = q0.pop_front();
          if ({bub0, k0, c0} !== {1'b0, e0}) begin
            n_bad++; $display("FAIL sb_s0_order: got b=%b %h required b=0 %h", bub0, {k0, c0}, e0);
          end
        end
      end
      if (up_valid && rdy1) q1.push_back({keep_in, ctrl_in});
      if (up_valid && rdy0) q0.push_back({keep_in, ctrl_in});
    end
  end

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({vld1, bub1, k1, c1, cnt1, rdy1} !== {1'b0, 1'b0, 72'h0, 24'h0, 2'd0, 1'b1}) begin
      n_bad++; $display("FAIL reset_s1: got v=%b b=%b k=%h c=%h n=%0d r=%b required 0/0/0/0/0/1",
                        vld1, bub1, k1, c1, cnt1, rdy1);
    end
    n_cmp++;
    if ({vld0, bub0, k0, c0, cnt0, rdy0} !== {1'b0, 1'b0, 72'h0, 24'h0, 2'd0, 1'b1}) begin
      n_bad++; $display("FAIL reset_s0: got v=%b b=%b k=%h c=%h n=%0d r=%b required 0/0/0/0/0/1",
                        vld0, bub0, k0, c0, cnt0, rdy0);
    end
    step; rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [KW-1:0] ek;
    logic [CW-1:0] ec;
    up_valid = 1'b1; dn_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ek = KW'(32'h1000 + 4 * i);
      ec = CW'(24'hABC + i);
      keep_in = ek; ctrl_in = ec;
      step;
      n_cmp++;
      if ({vld1, bub1, k1, c1, rdy1} !== {1'b1, 1'b0, ek, ec, 1'b1}) begin
        n_bad++; $display("FAIL b2b_s1[%0d]: got v=%b b=%b k=%h c=%h r=%b required 1/0/%h/%h/1",
                          i, vld1, bub1, k1, c1, rdy1, ek, ec);
      end
      n_cmp++;
      if ({vld0, bub0, k0, c0} !== {1'b1, 1'b0, ek, ec}) begin
        n_bad++; $display("FAIL b2b_s0[%0d]: got v=%b b=%b k=%h c=%h required 1/0/%h/%h",
                          i, vld0, bub0, k0, c0, ek, ec);
      end
    end
    up_valid = 1'b0;
    step;
    n_cmp++;
    if ({vld1, vld0} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_drain: got v1=%b v0=%b required 0/0", vld1, vld0);
    end
  endtask

  task automatic test_skid_stall;
    dn_ready = 1'b0; up_valid = 1'b1;
    keep_in = 72'hA0; ctrl_in = 24'h0A; step;
    n_cmp++;
    if ({vld1, k1, c1, rdy1} !== {1'b1, 72'hA0, 24'h0A, 1'b1}) begin
      n_bad++; $display("FAIL stall_A: got v=%b k=%h c=%h r=%b required 1/a0/0a/1", vld1, k1, c1, rdy1);
    end
    keep_in = 72'hB0; ctrl_in = 24'h0B; step;
    n_cmp++;
    if ({vld1, k1, c1, rdy1} !== {1'b1, 72'hA0, 24'h0A, 1'b0}) begin
      n_bad++; $display("FAIL stall_Bskid: got v=%b k=%h c=%h r=%b required 1/a0/0a/0", vld1, k1, c1, rdy1);
    end
    keep_in = 72'hC0; ctrl_in = 24'h0C; step;
    n_cmp++;
    if ({vld1, k1, c1, rdy1} !== {1'b1, 72'hA0, 24'h0A, 1'b0}) begin
      n_bad++; $display("FAIL stall_Cheld: got v=%b k=%h c=%h r=%b required 1/a0/0a/0", vld1, k1, c1, rdy1);
    end
    dn_ready = 1'b1; step;
    n_cmp++;
    if ({vld1, k1, c1, rdy1} !== {1'b1, 72'hB0, 24'h0B, 1'b1}) begin
      n_bad++; $display("FAIL stall_outB: got v=%b k=%h c=%h r=%b required 1/b0/0b/1", vld1, k1, c1, rdy1);
    end
    step;
    n_cmp++;
    if ({vld1, k1, c1} !== {1'b1, 72'hC0, 24'h0C}) begin
      n_bad++; $display("FAIL stall_outC: got v=%b k=%h c=%h required 1/c0/0c", vld1, k1, c1);
    end
    up_valid = 1'b0; step;
    n_cmp++;
    if ({vld1, vld0} !== 2'b00) begin
      n_bad++; $display("FAIL stall_drain: got v1=%b v0=%b required 0/0", vld1, vld0);
    end
  endtask

  task automatic test_flush;
    dn_ready = 1'b0; up_valid = 1'b1;
    keep_in = 72'h2000; ctrl_in = 24'h111; step;
    keep_in = 72'h2004; ctrl_in = 24'hFFF; flush = 1'b1; step;
    n_cmp++;
    if ({vld1, bub1, k1, c1, cnt1, rdy1} !== {1'b1, 1'b1, 72'h2004, 24'h0, 2'd1, 1'b1}) begin
      n_bad++; $display("FAIL flush_in_s1: got v=%b b=%b k=%h c=%h n=%0d r=%b required 1/1/2004/0/1/1",
                        vld1, bub1, k1, c1, cnt1, rdy1);
    end
    n_cmp++;
    if ({vld0, bub0, k0, c0, cnt0} !== {1'b0, 1'b0, 72'h2000, 24'h0, 2'd1}) begin
      n_bad++; $display("FAIL flush_in_s0: got v=%b b=%b k=%h c=%h n=%0d required 0/0/2000/0/1",
                        vld0, bub0, k0, c0, cnt0);
    end
    flush = 1'b0; keep_in = 72'h2008; ctrl_in = 24'h222; step;
    n_cmp++;
    if ({rdy1, bub1, vld0, bub0, k0} !== {1'b0, 1'b1, 1'b1, 1'b0, 72'h2008}) begin
      n_bad++; $display("FAIL flush_fill: got r1=%b b1=%b v0=%b b0=%b k0=%h required 0/1/1/0/2008",
                        rdy1, bub1, vld0, bub0, k0);
    end
    up_valid = 1'b0; flush = 1'b1; step;
    n_cmp++;
    if ({vld1, bub1, k1, c1, cnt1, rdy1} !== {1'b0, 1'b0, 72'h2004, 24'h0, 2'd2, 1'b1}) begin
      n_bad++; $display("FAIL flush_idle_s1: got v=%b b=%b k=%h c=%h n=%0d r=%b required 0/0/2004/0/2/1",
                        vld1, bub1, k1, c1, cnt1, rdy1);
    end
    n_cmp++;
    if ({vld0, bub0, k0, c0, cnt0} !== {1'b0, 1'b0, 72'h2008, 24'h0, 2'd2}) begin
      n_bad++; $display("FAIL flush_idle_s0: got v=%b b=%b k=%h c=%h n=%0d required 0/0/2008/0/2",
                        vld0, bub0, k0, c0, cnt0);
    end
    flush = 1'b0; step;
    n_cmp++;
    if ({vld1, vld0, k1} !== {1'b0, 1'b0, 72'h2004}) begin
      n_bad++; $display("FAIL flush_skid_gone: got v1=%b v0=%b k1=%h required 0/0/2004", vld1, vld0, k1);
    end
  endtask

  task automatic test_flush_cnt;
    logic [1:0] en;
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({cnt1, cnt0} !== 4'h0) begin
      n_bad++; $display("FAIL cnt_reset: got %0d/%0d required 0/0", cnt1, cnt0);
    end
    step; rst_n = 1'b1; flush = 1'b1; up_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = (i < 2) ? 2'(i + 1) : 2'd3;
      step;
      n_cmp++;
      if ({cnt1, cnt0} !== {en, en}) begin
        n_bad++; $display("FAIL cnt_sat[%0d]: got %0d/%0d required %0d", i, cnt1, cnt0, en);
      end
    end
    flush = 1'b0; step;
    n_cmp++;
    if ({cnt1, cnt0} !== 4'hF) begin
      n_bad++; $display("FAIL cnt_hold: got %0d/%0d required 3/3", cnt1, cnt0);
    end
  endtask

  task automatic test_async_reset;
    dn_ready = 1'b0; up_valid = 1'b1;
    keep_in = 72'h4000; ctrl_in = 24'h444; step;
    keep_in = 72'h4004; ctrl_in = 24'h555; step;
    n_cmp++;
    if ({vld1, rdy1} !== 2'b10) begin
      n_bad++; $display("FAIL arst_full: got v=%b r=%b required 1/0", vld1, rdy1);
    end
    up_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vld1, rdy1, bub1, k1, c1} !== {1'b0, 1'b1, 1'b0, 72'h0, 24'h0}) begin
      n_bad++; $display("FAIL arst_s1: got v=%b r=%b b=%b k=%h c=%h required 0/1/0/0/0", vld1, rdy1, bub1, k1, c1);
    end
    n_cmp++;
    if ({vld0, rdy0, k0} !== {1'b0, 1'b1, 72'h0}) begin
      n_bad++; $display("FAIL arst_s0: got v=%b r=%b k=%h required 0/1/0", vld0, rdy0, k0);
    end
    step; rst_n = 1'b1;
  endtask

  task automatic test_random;
    q1.delete(); q0.delete();
    sb_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      up_valid = ($urandom_range(0, 3) != 0);
      dn_ready = ($urandom_range(0, 1) != 0);
      keep_in  = KW'(32'h5000_0000 + i);
      ctrl_in  = CW'($urandom);
      step;
    end
    up_valid = 1'b0; dn_ready = 1'b1;
    repeat (4) step;
    sb_en = 1'b0;
    n_cmp++;
    if (q1.size() != 0 || q0.size() != 0) begin
      n_bad++; $display("FAIL rand_drop: got %0d/%0d entries left required 0/0", q1.size(), q0.size());
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_skid_stall;
    test_flush;
    test_flush_cnt;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
